// File: rtl/register_writeback_unit.sv
// Purpose: picks the retiring instruction's result, queues pending register writes, and answers bypass queries.
// Latency: an accepted write reaches rf_* one cycle after its handshake edge; bypass is combinational from queue state.
// Backpressure: wb_ready drops when the queue is full; rf_* holds the head until rf_ready dequeues it.
module register_writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [4:0]               rd,
    input  logic [XLEN-1:0]          alu_result,
    input  logic [XLEN-1:0]          immediate,
    input  logic [XLEN-1:0]          memory_result,
    input  logic [XLEN-1:0]          pc,
    output logic                     rf_we,
    output logic [4:0]               rf_addr,
    output logic [XLEN-1:0]          rf_data,
    input  logic                     rf_ready,
    input  logic [4:0]               fwd_rd,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t       queue [DEPTH];
    wb_entry_t       head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   idx;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] sel_data;
    logic            sel_writes;
    logic            enq;
    logic            deq;

    always_comb begin
        load_val = '0;
        case (funct3)
            3'b000:  load_val = {{(XLEN-8){memory_result[7]}}, memory_result[7:0]};
            3'b001:  load_val = {{(XLEN-16){memory_result[15]}}, memory_result[15:0]};
            3'b010:  load_val = memory_result;
            3'b100:  load_val = {{(XLEN-8){1'b0}}, memory_result[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, memory_result[15:0]};
            default: load_val = '0;
        endcase
    end

    always_comb begin
        sel_writes = 1'b1;
        sel_data   = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: sel_data = alu_result;
            OPC_LOAD:                      sel_data = load_val;
            OPC_LUI:                       sel_data = immediate;
            OPC_JAL, OPC_JALR:             sel_data = pc + XLEN'(4);
            default:                       sel_writes = 1'b0;
        endcase
    end

    // wb_ready is taken from registered count only, so a full queue never reuses a slot freed this cycle.
    assign wb_ready = (count < CW'(DEPTH));
    assign enq      = wb_valid && wb_ready && sel_writes && (rd != 5'd0);
    assign deq      = rf_we && rf_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) queue[wr_ptr] <= {rd, sel_data};
    end

    assign head    = queue[rd_ptr];
    assign rf_we   = (count != '0);
    assign rf_addr = rf_we ? head.rd   : 5'd0;
    assign rf_data = rf_we ? head.data : '0;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (fwd_rd != 5'd0) && (queue[idx].rd == fwd_rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = queue[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_register_writeback_unit.sv
// Scoreboard bench for register_writeback_unit: DEPTH=2 instance for scenarios, DEPTH=4 instance for pointer wrap.
module tb_register_writeback_unit;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0]  LOAD_F3  [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011};
    localparam logic [31:0] LOAD_EXP [6] = '{32'hFFFFFFF0, 32'hFFFF80F0, 32'h000000F0,
                                             32'h000080F0, 32'h000080F0, 32'h00000000};

    logic            clk = 1'b0;
    logic            reset;
    logic            wb_valid, wb_ready, wb_valid4, wb_ready4;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result, immediate, memory_result, pc;
    logic            rf_we, rf_ready, rf_we4, rf_ready4;
    logic [4:0]      rf_addr, rf_addr4, fwd_rd;
    logic [XLEN-1:0] rf_data, rf_data4, fwd_data, fwd_data4;
    logic            fwd_hit, fwd_hit4;
    logic [1:0]      count;
    logic [2:0]      count4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] sb[$];
    logic [36:0] sb4[$];

    always #5 clk = ~clk;

    register_writeback_unit #(.XLEN(XLEN), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd),
        .alu_result(alu_result), .immediate(immediate), .memory_result(memory_result), .pc(pc),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_ready(rf_ready),
        .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    register_writeback_unit #(.XLEN(XLEN), .DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .wb_valid(wb_valid4), .wb_ready(wb_ready4),
        .opcode(opcode), .funct3(funct3), .rd(rd),
        .alu_result(alu_result), .immediate(immediate), .memory_result(memory_result), .pc(pc),
        .rf_we(rf_we4), .rf_addr(rf_addr4), .rf_data(rf_data4), .rf_ready(rf_ready4),
        .fwd_rd(fwd_rd), .fwd_hit(fwd_hit4), .fwd_data(fwd_data4), .count(count4)
    );

    // Reference result: {writes, value}.
    function automatic logic [XLEN:0] model_result(input logic [6:0] op, input logic [2:0] f3,
                                                   input logic [XLEN-1:0] alu, imm, mem, pcv);
        case (op)
            OPC_OP, OPC_OP_IMM, OPC_AUIPC: return {1'b1, alu};
            OPC_LUI:                       return {1'b1, imm};
            OPC_JAL, OPC_JALR:             return {1'b1, pcv + 32'd4};
            OPC_LOAD: begin
                case (f3)
                    3'b000:  return {1'b1, {{24{mem[7]}}, mem[7:0]}};
                    3'b001:  return {1'b1, {{16{mem[15]}}, mem[15:0]}};
                    3'b010:  return {1'b1, mem};
                    3'b100:  return {1'b1, 24'd0, mem[7:0]};
                    3'b101:  return {1'b1, 16'd0, mem[15:0]};
                    default: return {1'b1, 32'd0};
                endcase
            end
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    // One clock of the DEPTH=2 instance: scoreboard pop/push at negedge, returns 1 after the next posedge.
    task automatic clock_cycle();
        logic [XLEN:0] r;
        logic [36:0]   exp_e;
        @(negedge clk);
        n_checks++;
        if (int'(count) !== sb.size() || rf_we !== (sb.size() != 0) || wb_ready !== (sb.size() < 2)) begin
            n_fail++;
            $display("FAIL queue_state: count=%0d rf_we=%b wb_ready=%b, expected count=%0d", count, rf_we, wb_ready, sb.size());
        end
        if (rf_we !== 1'b1) begin
            n_checks++;
            if (rf_addr !== 5'd0 || rf_data !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_outputs: rf_addr=%0d rf_data=%h, expected 0/0", rf_addr, rf_data);
            end
        end
        if (rf_we === 1'b1 && rf_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: rf_addr=%0d rf_data=%h, expected no write", rf_addr, rf_data);
            end else begin
                exp_e = sb.pop_front();
                if ({rf_addr, rf_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL rf_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                             rf_addr, rf_data, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
        if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
            r = model_result(opcode, funct3, alu_result, immediate, memory_result, pc);
            if (r[XLEN] && rd != 5'd0) sb.push_back({rd, r[XLEN-1:0]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0 || fwd_hit !== 1'b0 ||
            fwd_data !== 32'd0 || wb_ready !== 1'b1 || count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: rf_we=%b addr=%0d data=%h hit=%b fwd=%h ready=%b count=%0d, expected 0/0/0/0/0/1/0",
                     rf_we, rf_addr, rf_data, fwd_hit, fwd_data, wb_ready, count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        rf_ready = 1'b1;
        opcode = OPC_OP; rd = 5'd5; alu_result = 32'h1234; wb_valid = 1'b1;
        clock_cycle();
        wb_valid = 1'b0;
        n_checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL single_write: rf_we=%b addr=%0d data=%h, expected 1/5/00001234", rf_we, rf_addr, rf_data);
        end
        clock_cycle();
        n_checks++;
        if (rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_write_done: rf_we=%b, expected 0", rf_we);
        end
    endtask

    task automatic test_load_extension();
        rf_ready = 1'b1;
        opcode = OPC_LOAD; memory_result = 32'h000080F0;
        for (int i = 0; i < 6; i++) begin
            funct3 = LOAD_F3[i]; rd = 5'(8 + i); wb_valid = 1'b1;
            clock_cycle();
            n_checks++;
            if (rf_data !== LOAD_EXP[i] || rf_addr !== 5'(8 + i)) begin
                n_fail++;
                $display("FAIL load_ext f3=%b: addr=%0d data=%h, expected %0d/%h", LOAD_F3[i], rf_addr, rf_data, 8 + i, LOAD_EXP[i]);
            end
        end
        wb_valid = 1'b0;
        clock_cycle();
        clock_cycle();
    endtask

    task automatic test_backpressure();
        rf_ready = 1'b0;
        opcode = OPC_JAL; rd = 5'd1; pc = 32'h100; alu_result = 32'hDEAD; wb_valid = 1'b1;
        clock_cycle();
        opcode = OPC_LUI; rd = 5'd2; immediate = 32'hABCDE000;
        clock_cycle();
        opcode = OPC_OP; rd = 5'd3; alu_result = 32'h33;
        for (int i = 0; i < 3; i++) begin
            clock_cycle();
            n_checks++;
            if (count !== 2'd2 || wb_ready !== 1'b0 || rf_addr !== 5'd1 || rf_data !== 32'h104) begin
                n_fail++;
                $display("FAIL backpressure_hold: count=%0d ready=%b addr=%0d data=%h, expected 2/0/1/00000104",
                         count, wb_ready, rf_addr, rf_data);
            end
        end
        rf_ready = 1'b1;
        clock_cycle();
        n_checks++;
        if (count !== 2'd1 || rf_data !== 32'hABCDE000) begin
            n_fail++;
            $display("FAIL no_slot_reuse: count=%0d data=%h, expected 1/abcde000", count, rf_data);
        end
        clock_cycle();
        wb_valid = 1'b0;
        n_checks++;
        if (count !== 2'd1 || rf_data !== 32'h33 || rf_addr !== 5'd3) begin
            n_fail++;
            $display("FAIL held_offer: count=%0d addr=%0d data=%h, expected 1/3/00000033", count, rf_addr, rf_data);
        end
        clock_cycle();
    endtask

    task automatic test_bypass();
        rf_ready = 1'b0;
        opcode = OPC_OP; rd = 5'd7; alu_result = 32'h11; wb_valid = 1'b1;
        clock_cycle();
        fwd_rd = 5'd7; alu_result = 32'h22;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin
            n_fail++;
            $display("FAIL bypass_one: hit=%b data=%h, expected 1/00000011", fwd_hit, fwd_data);
        end
        clock_cycle();
        wb_valid = 1'b0;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin
            n_fail++;
            $display("FAIL bypass_youngest: hit=%b data=%h, expected 1/00000022", fwd_hit, fwd_data);
        end
        fwd_rd = 5'd0;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL bypass_x0: hit=%b data=%h, expected 0/0", fwd_hit, fwd_data);
        end
        fwd_rd = 5'd9; rd = 5'd9; alu_result = 32'h99; wb_valid = 1'b1;
        #1;
        n_checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL bypass_miss: hit=%b data=%h, expected 0/0", fwd_hit, fwd_data);
        end
        wb_valid = 1'b0; fwd_rd = 5'd7; rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) clock_cycle();
        n_checks++;
        if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL bypass_drained: hit=%b data=%h, expected 0/0", fwd_hit, fwd_data);
        end
    endtask

    task automatic test_discards();
        logic [6:0] ops [3];
        logic [4:0] rds [3];
        ops = '{OPC_BRANCH, OPC_STORE, OPC_OP};
        rds = '{5'd5, 5'd6, 5'd0};
        rf_ready = 1'b1; alu_result = 32'h5A5A;
        for (int i = 0; i < 3; i++) begin
            opcode = ops[i]; rd = rds[i]; wb_valid = 1'b1;
            #1;
            n_checks++;
            if (wb_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL discard_ready[%0d]: wb_ready=%b, expected 1", i, wb_ready);
            end
            clock_cycle();
            n_checks++;
            if (count !== 2'd0 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL discard[%0d]: count=%0d rf_we=%b, expected 0/0", i, count, rf_we);
            end
        end
        wb_valid = 1'b0;
        clock_cycle();
    endtask

    task automatic test_reset_mid_operation();
        rf_ready = 1'b0; opcode = OPC_OP; wb_valid = 1'b1;
        rd = 5'd4; alu_result = 32'h44;
        clock_cycle();
        rd = 5'd5; alu_result = 32'h55;
        clock_cycle();
        wb_valid = 1'b0; fwd_rd = 5'd4;
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        n_checks++;
        if (rf_we !== 1'b0 || count !== 2'd0 || wb_ready !== 1'b1 || fwd_hit !== 1'b0 || rf_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: rf_we=%b count=%0d ready=%b hit=%b data=%h, expected 0/0/1/0/0",
                     rf_we, count, wb_ready, fwd_hit, rf_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) clock_cycle();
    endtask

    task automatic test_wrap_depth4();
        int sent = 0;
        int got  = 0;
        logic [36:0] e;
        opcode = OPC_OP; funct3 = 3'b000; rf_ready = 1'b0; wb_valid = 1'b0;
        rd = 5'd1; alu_result = 32'h1000; wb_valid4 = 1'b1; rf_ready4 = 1'b0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (int'(count4) !== sb4.size() || wb_ready4 !== (sb4.size() < 4)) begin
                n_fail++;
                $display("FAIL wrap_state: count=%0d ready=%b, expected count=%0d", count4, wb_ready4, sb4.size());
            end
            if (rf_we4 === 1'b1 && rf_ready4 === 1'b1) begin
                n_checks++;
                got++;
                if (sb4.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_unexpected: addr=%0d data=%h, expected no write", rf_addr4, rf_data4);
                end else begin
                    e = sb4.pop_front();
                    if ({rf_addr4, rf_data4} !== e) begin
                        n_fail++;
                        $display("FAIL wrap_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                                 rf_addr4, rf_data4, e[36:32], e[31:0]);
                    end
                end
            end
            if (wb_valid4 === 1'b1 && wb_ready4 === 1'b1) begin
                sb4.push_back({rd, alu_result});
                sent++;
            end
            @(posedge clk);
            #1;
            wb_valid4  = (sent < 10);
            rd         = 5'(sent + 1);
            alu_result = 32'h1000 + 32'(sent);
            rf_ready4  = ($urandom_range(0, 2) == 0);
        end
        wb_valid4 = 1'b0;
        n_checks++;
        if (got !== 10) begin
            n_fail++;
            $display("FAIL wrap_complete: drained %0d writes, expected 10 within cycle budget", got);
        end
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_valid4 = 1'b0; rf_ready = 1'b0; rf_ready4 = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; rd = 5'd0; fwd_rd = 5'd0;
        alu_result = '0; immediate = '0; memory_result = '0; pc = '0;
        test_reset();
        test_single_write();
        test_load_extension();
        test_backpressure();
        test_bypass();
        test_discards();
        test_reset_mid_operation();
        test_wrap_depth4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_writeback_unit.md
REGISTER_WRITEBACK_UNIT -- requirements
Module: register_writeback_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width in bits (minimum 16).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the pending-write queue depth (power of two, 2..8).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port wb_valid, input, 1, meaning the register-update stage offers one retiring instruction this cycle.
REQ-006 The block SHALL have port wb_ready, output, 1, meaning the block can accept an offer; it is 1 iff count < DEPTH.
REQ-007 The block SHALL have ports opcode [6:0], funct3 [2:0] and rd [4:0], all inputs, meaning the retiring instruction fields.
REQ-008 The block SHALL have ports alu_result, immediate, memory_result and pc, all inputs, XLEN wide, meaning the candidate result sources.
REQ-009 The block SHALL have ports rf_we (1), rf_addr (5) and rf_data (XLEN), all outputs, meaning the register-file write port driven from the queue head.
REQ-010 The block SHALL have port rf_ready, input, 1, meaning the register file accepts the head write this cycle.
REQ-011 The block SHALL have ports fwd_rd [4:0] (input), fwd_hit (1, output) and fwd_data (XLEN, output), meaning the bypass query for a pending write.
REQ-012 The block SHALL have port count, output, clog2(DEPTH)+1 bits, meaning the number of queued writes.

Function
REQ-013 Result selection SHALL be:
- OP, OP_IMM, AUIPC -> alu_result.
- LOAD -> extended memory_result.
- LUI -> immediate.
- JAL, JALR -> pc + 4, modulo 2^XLEN.
REQ-014 LOAD extension SHALL use funct3:
- 000 -> sign-extend bits [7:0].
- 001 -> sign-extend bits [15:0].
- 010 -> bits [XLEN-1:0].
- 100 -> zero-extend [7:0].
- 101 -> zero-extend [15:0].
- Any other value -> 0, still written.
REQ-015 A handshake SHALL occur when wb_valid=1 and wb_ready=1.
REQ-016 On a handshake with a writing opcode (REQ-013) and rd != 0, the block SHALL enqueue {rd, selected value} at the tail.
REQ-017 On a handshake with any other opcode, or with rd = 0, the block SHALL accept and discard the instruction; count is unchanged.
REQ-018 rf_we SHALL be 1 iff count != 0.
REQ-019 rf_addr and rf_data SHALL show the head entry when count != 0 and SHALL be 0 otherwise.
REQ-020 An entry enqueued at edge N SHALL become visible on rf_* no earlier than the cycle after edge N (one-cycle minimum latency); there is no combinational input-to-rf path.
REQ-021 A dequeue SHALL occur when rf_we=1 and rf_ready=1; the head advances at the next edge.
REQ-022 rf_* SHALL hold stable while rf_we=1 and rf_ready=0.
REQ-023 A simultaneous enqueue and dequeue SHALL leave count unchanged and update both pointers.
REQ-024 When full, wb_ready SHALL be 0 even if a dequeue occurs in the same cycle; there is no same-cycle slot reuse.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 fwd_hit SHALL be 1 iff fwd_rd != 0 and some queued entry has rd = fwd_rd.
REQ-027 fwd_data SHALL be the value of the youngest matching entry, and 0 when fwd_hit = 0.
REQ-028 The bypass SHALL be combinational from queue state and fwd_rd only; in-flight offers are not forwarded.
REQ-029 A wb_valid offer presented while wb_ready=0 SHALL be ignored; the offering stage holds it.

Reset
REQ-030 While reset=1, the block SHALL asynchronously force count=0 and both pointers to 0, giving rf_we=0, rf_addr=0, rf_data=0, fwd_hit=0, fwd_data=0 and wb_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all queued writes; no rf_we pulse occurs during or after the reset cycle until a new handshake.
REQ-032 Queue storage contents need not be reset, but they SHALL never be observable while count=0.

Verification
REQ-033 Bench scenario (single write): OP, rd=5, alu_result=0x1234, rf_ready=1 -> next cycle rf_we=1, rf_addr=5, rf_data=0x1234; following cycle rf_we=0.
REQ-034 Bench scenario (load extension): LOAD with memory_result=0x000080F0 -> funct3 000 gives 0xFFFFFFF0; 001 gives 0xFFFF80F0; 100 gives 0x000000F0; 101 gives 0x000080F0.
REQ-035 Bench scenario (backpressure): rf_ready=0 with JAL pc=0x100 rd=1 then LUI rd=2 imm=0xABCDE000 -> count=2, wb_ready=0, rf_data=0x104 held; releasing rf_ready gives 0x104 then 0xABCDE000 in order.
REQ-036 Bench scenario (bypass): queue holds rd=7/0x11 then rd=7/0x22 -> fwd_rd=7 gives fwd_hit=1, fwd_data=0x22; fwd_rd=0 gives fwd_hit=0.
REQ-037 Bench scenario (discards): BRANCH, STORE, or OP with rd=0 -> handshake completes, count stays 0, rf_we never asserts.
REQ-038 Bench scenario (reset mid-operation): queue full with rf_ready=0, assert reset mid-cycle -> rf_we=0 and count=0 immediately, wb_ready=1; DEPTH=4 wrap test passes 10 writes in order.
